// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants and fetch entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  localparam int FETCH_W = $bits(fetch_entry_t);
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO of fetched {instr, pc} entries
module fetch_queue import riscv_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [FETCH_W-1:0]       push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [FETCH_W-1:0]       head
);
  localparam int AW = $clog2(DEPTH);

  logic [FETCH_W-1:0] mem_q [DEPTH];
  logic [FETCH_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               do_pop;

  always_comb begin
    do_pop   = pop & (count_q != '0);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // A full queue may push and pop together: the head is read from mem_q before the write lands.
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, credit-limited imem requests, redirect flush
module fetch_unit import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pcplus4
);
  localparam int             CW      = $clog2(QDEPTH) + 1;
  localparam logic [CW:0]    CREDITS = (CW+1)'(QDEPTH);

  logic [31:0]        pc_q, pc_d, spc_q, spc_d, last_pc_q, last_pc_d, target;
  logic [CW-1:0]      outstanding_q, outstanding_d, discard_q, discard_d, count;
  logic [FETCH_W-1:0] head_bits, push_data;
  fetch_entry_t       head;
  logic               hs, resp, push, pop;
  logic               unused_pc_lsbs;

  assign target         = {redirect_pc[31:2], 2'b00};
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  assign imem_req  = !reset && !redirect && (({1'b0, outstanding_q} + {1'b0, count}) < CREDITS);
  assign imem_addr = pc_q;
  assign hs        = imem_req & imem_ready;
  // Stray responses with nothing outstanding are ignored so the counters never underflow.
  assign resp      = imem_rvalid & (outstanding_q != '0);
  assign push      = resp & (discard_q == '0) & !redirect;
  assign id_valid  = !reset && (count != '0);
  assign pop       = id_valid & id_ready & !redirect;
  assign push_data = {imem_rdata, spc_q};
  assign head      = fetch_entry_t'(head_bits);

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head_bits)
  );

  always_comb begin
    pc_d          = pc_q;
    spc_d         = spc_q;
    last_pc_d     = last_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(hs) - CW'(resp);
    if (redirect) begin
      // Everything still in flight belongs to the old path and must be dropped on return.
      pc_d      = target;
      spc_d     = target;
      discard_d = outstanding_d;
    end else begin
      if (hs) pc_d = pc_q + 32'd4;
      if (push) spc_d = spc_q + 32'd4;
      if (resp && discard_q != '0) discard_d = discard_q - 1'b1;
      if (pop) last_pc_d = head.pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      spc_q         <= RESET_PC;
      last_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      spc_q         <= spc_d;
      last_pc_q     <= last_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  always_comb begin
    id_instr = NOP_INSTR;
    id_pc    = last_pc_q;
    if (reset) begin
      id_pc = RESET_PC;
    end else if (id_valid) begin
      id_instr = head.instr;
      id_pc    = head.pc;
    end
  end

  assign id_pcplus4 = id_pc + 32'd4;

  a_no_stray_resp: assert property (@(posedge clk) disable iff (reset)
    !(imem_rvalid && outstanding_q == '0));
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] TAG = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic        id_ready = 1'b0;
  logic        imem_ready = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] redirect_pc = '0;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] got_pc [$];
  logic [31:0] got_ins [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        req, rvalid = 1'b0, valid;
    logic [31:0] addr, rdata = '0, instr, pc, pcp4;
    logic [31:0] pend [$];
    int          pend_n = 0;

    fetch_unit #(.RESET_PC(g == 0 ? 32'h0000_0000 : 32'hFFFF_FFFC), .QDEPTH(2)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (req),
      .imem_addr   (addr),
      .imem_ready  (imem_ready),
      .imem_rvalid (rvalid),
      .imem_rdata  (rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_valid    (valid),
      .id_ready    (id_ready),
      .id_instr    (instr),
      .id_pc       (pc),
      .id_pcplus4  (pcp4)
    );

    // In-order memory: a request accepted at one edge answers during the following cycle unless held.
    always @(posedge clk) begin
      if (reset) begin
        pend.delete();
        rvalid <= 1'b0;
      end else begin
        rvalid <= 1'b0;
        if (req && imem_ready) pend.push_back(addr);
        if (!hold && pend.size() != 0) begin
          rvalid <= 1'b1;
          rdata  <= pend[0] + TAG;
          void'(pend.pop_front());
        end
      end
      pend_n <= pend.size();
    end
  end

  task automatic start(input logic rdy);
    @(negedge clk);
    reset = 1'b1; redirect = 1'b0; hold = 1'b0; imem_ready = 1'b1; id_ready = rdy;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic collect(input int cycles);
    got_pc.delete();
    got_ins.delete();
    for (int c = 0; c < cycles; c++) begin
      #1;
      if (g_dut[0].valid && id_ready) begin
        got_pc.push_back(g_dut[0].pc);
        got_ins.push_back(g_dut[0].instr);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; imem_ready = 1'b1; id_ready = 1'b1; redirect = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (g_dut[0].req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", g_dut[0].req); end
    checks++; if (g_dut[0].valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", g_dut[0].valid); end
    checks++; if (g_dut[0].instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h want 00000013", g_dut[0].instr); end
    checks++; if (g_dut[0].pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 00000000", g_dut[0].pc); end
    checks++; if (g_dut[0].pcp4 !== 32'h4) begin errors++; $display("FAIL reset_pcplus4: got %h want 00000004", g_dut[0].pcp4); end
    checks++; if (g_dut[1].pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc_hi: got %h want fffffffc", g_dut[1].pc); end
    checks++; if (g_dut[1].pcp4 !== 32'h0) begin errors++; $display("FAIL reset_pcplus4_hi: got %h want 00000000", g_dut[1].pcp4); end
  endtask

  task automatic test_startup();
    start(1'b1);
    checks++; if (g_dut[0].req !== 1'b1 || g_dut[0].addr !== 32'h0) begin errors++; $display("FAIL start_req0: got req=%b addr=%h want 1/00000000", g_dut[0].req, g_dut[0].addr); end
    @(negedge clk); #1;
    checks++; if (g_dut[0].valid !== 1'b0 || g_dut[0].addr !== 32'h4) begin errors++; $display("FAIL start_cyc1: got valid=%b addr=%h want 0/00000004", g_dut[0].valid, g_dut[0].addr); end
    @(negedge clk); #1;
    checks++; if (g_dut[0].valid !== 1'b1 || g_dut[0].pc !== 32'h0 || g_dut[0].pcp4 !== 32'h4) begin errors++; $display("FAIL start_first: got valid=%b pc=%h pc4=%h want 1/0/4", g_dut[0].valid, g_dut[0].pc, g_dut[0].pcp4); end
    checks++; if (g_dut[0].instr !== TAG) begin errors++; $display("FAIL start_instr0: got %h want %h", g_dut[0].instr, TAG); end
    @(negedge clk); #1;
    checks++; if (g_dut[0].valid !== 1'b1 || g_dut[0].pc !== 32'h4 || g_dut[0].pcp4 !== 32'h8) begin errors++; $display("FAIL start_second: got valid=%b pc=%h pc4=%h want 1/4/8", g_dut[0].valid, g_dut[0].pc, g_dut[0].pcp4); end
    checks++; if (g_dut[0].instr !== TAG + 32'h4) begin errors++; $display("FAIL start_instr1: got %h want %h", g_dut[0].instr, TAG + 32'h4); end
  endtask

  task automatic test_wrap();
    start(1'b1);
    checks++; if (g_dut[1].addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h want fffffffc", g_dut[1].addr); end
    @(negedge clk); #1;
    checks++; if (g_dut[1].addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got %h want 00000000", g_dut[1].addr); end
    @(negedge clk); #1;
    checks++; if (g_dut[1].valid !== 1'b1 || g_dut[1].pc !== 32'hFFFF_FFFC || g_dut[1].pcp4 !== 32'h0) begin errors++; $display("FAIL wrap_first: got valid=%b pc=%h pc4=%h want 1/fffffffc/0", g_dut[1].valid, g_dut[1].pc, g_dut[1].pcp4); end
    checks++; if (g_dut[1].instr !== 32'h0FFF_FFFC) begin errors++; $display("FAIL wrap_instr: got %h want 0ffffffc", g_dut[1].instr); end
    @(negedge clk); #1;
    checks++; if (g_dut[1].pc !== 32'h0 || g_dut[1].pcp4 !== 32'h4) begin errors++; $display("FAIL wrap_second: got pc=%h pc4=%h want 0/4", g_dut[1].pc, g_dut[1].pcp4); end
  endtask

  task automatic test_stall();
    start(1'b0);
    repeat (3) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (g_dut[0].valid !== 1'b1 || g_dut[0].pc !== 32'h0 || g_dut[0].instr !== TAG || g_dut[0].req !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: got valid=%b pc=%h instr=%h req=%b want 1/0/%h/0", c, g_dut[0].valid, g_dut[0].pc, g_dut[0].instr, g_dut[0].req, TAG);
      end
      @(negedge clk);
    end
    #1;
    checks++; if (g_dut[0].addr !== 32'h8) begin errors++; $display("FAIL stall_addr: got %h want 00000008", g_dut[0].addr); end
    id_ready = 1'b1;
    collect(30);
    checks++; if (got_pc.size() < 8) begin errors++; $display("FAIL stall_count: got %0d pops want >=8", got_pc.size()); end
    for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
      checks++;
      if (got_pc[i] !== 32'(4 * i) || got_ins[i] !== TAG + 32'(4 * i)) begin
        errors++; $display("FAIL stall_order%0d: got pc=%h instr=%h want %h", i, got_pc[i], got_ins[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    start(1'b1);
    @(negedge clk);
    @(negedge clk);
    hold = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (g_dut[0].req !== 1'b0 || g_dut[0].valid !== 1'b0 || g_dut[0].pend_n != 2) begin errors++; $display("FAIL redir_inflight: got req=%b valid=%b pend=%0d want 0/0/2", g_dut[0].req, g_dut[0].valid, g_dut[0].pend_n); end
    checks++; if (g_dut[0].pc !== 32'h4 || g_dut[0].instr !== 32'h0000_0013) begin errors++; $display("FAIL redir_empty_out: got pc=%h instr=%h want 4/00000013", g_dut[0].pc, g_dut[0].instr); end
    redirect = 1'b1; redirect_pc = 32'h0000_0100; hold = 1'b0;
    #1;
    checks++; if (g_dut[0].req !== 1'b0) begin errors++; $display("FAIL redir_req_low: got %b want 0", g_dut[0].req); end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (g_dut[0].addr !== 32'h100) begin errors++; $display("FAIL redir_addr: got %h want 00000100", g_dut[0].addr); end
    collect(20);
    checks++; if (got_pc.size() < 2) begin errors++; $display("FAIL redir_count: got %0d pops want >=2", got_pc.size()); end
    else begin
      checks++; if (got_pc[0] !== 32'h100 || got_ins[0] !== 32'h1000_0100) begin errors++; $display("FAIL redir_first: got pc=%h instr=%h want 00000100/10000100", got_pc[0], got_ins[0]); end
      checks++; if (got_pc[1] !== 32'h104) begin errors++; $display("FAIL redir_second: got %h want 00000104", got_pc[1]); end
    end
  endtask

  task automatic test_align();
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (g_dut[0].addr !== 32'h200) begin errors++; $display("FAIL align_addr: got %h want 00000200", g_dut[0].addr); end
    collect(20);
    checks++; if (got_pc.size() < 2 || got_pc[0] !== 32'h200 || got_pc[1] !== 32'h204) begin errors++; $display("FAIL align_pcs: got n=%0d first=%h want 00000200,00000204", got_pc.size(), got_pc.size() ? got_pc[0] : 32'hx); end
  endtask

  task automatic test_coincident();
    start(1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (g_dut[0].valid !== 1'b1 || g_dut[0].rvalid !== 1'b1) begin errors++; $display("FAIL coin_setup: got valid=%b rvalid=%b want 1/1", g_dut[0].valid, g_dut[0].rvalid); end
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (g_dut[0].valid !== 1'b0) begin errors++; $display("FAIL coin_flushed: got valid=%b want 0", g_dut[0].valid); end
    checks++; if (g_dut[0].req !== 1'b1 || g_dut[0].addr !== 32'h40) begin errors++; $display("FAIL coin_refetch: got req=%b addr=%h want 1/00000040", g_dut[0].req, g_dut[0].addr); end
    collect(20);
    checks++; if (got_pc.size() < 3 || got_pc[0] !== 32'h40 || got_pc[1] !== 32'h44 || got_pc[2] !== 32'h48) begin errors++; $display("FAIL coin_pcs: got n=%0d first=%h want 00000040,44,48", got_pc.size(), got_pc.size() ? got_pc[0] : 32'hx); end
  endtask

  task automatic test_back_to_back();
    start(1'b1);
    repeat (2) @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    @(negedge clk);
    redirect_pc = 32'h0000_0400;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    checks++; if (g_dut[0].addr !== 32'h400) begin errors++; $display("FAIL b2b_addr: got %h want 00000400", g_dut[0].addr); end
    collect(20);
    checks++; if (got_pc.size() < 2 || got_pc[0] !== 32'h400 || got_pc[1] !== 32'h404) begin errors++; $display("FAIL b2b_pcs: got n=%0d first=%h want 00000400,00000404", got_pc.size(), got_pc.size() ? got_pc[0] : 32'hx); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_wrap();
    test_stall();
    test_redirect();
    test_align();
    test_coincident();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
